// File: rtl/sram_like_responder.sv
// Responder end of a req/addr_ok/data_ok SRAM-like bus with a 32-bit word memory.
// Accepts pipelined requests and answers in order after at least LAT cycles.
module sram_like_responder #(
    parameter int AW     = 10,
    parameter int QDEPTH = 4,
    parameter int LAT    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    input  logic        resp_stall,
    input  logic        addr_block
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [CW-1:0] cnt_q [QDEPTH];
    logic [CW-1:0] cnt_d [QDEPTH];
    logic [31:0]   q_data [QDEPTH];
    logic [31:0]   mem [2**AW];

    logic [AW-1:0] idx;
    logic          accept;
    logic          head_ready;
    logic          retire;
    logic          unused_bits;

    // Transfer size is informational; wstrb alone decides which bytes are written.
    assign unused_bits = ^{size, addr[31:AW+2], addr[1:0]};

    assign idx        = addr[AW+1:2];
    assign addr_ok    = resetn & ~addr_block & (count_q < (PW+1)'(QDEPTH));
    assign accept     = req & addr_ok;
    assign head_ready = (count_q != '0) && (cnt_q[rd_ptr_q] == '0);
    assign data_ok    = head_ready & ~resp_stall;
    assign retire     = data_ok;
    assign rdata      = data_ok ? q_data[rd_ptr_q] : 32'h0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (retire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({accept, retire})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
        for (int i = 0; i < QDEPTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept && (wr_ptr_q == PW'(i))) begin
                cnt_d[i] = CW'(LAT - 1);
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < QDEPTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Memory and response data are not reset; a read captures the word at its accept edge,
    // so later writes cannot alter an already-accepted read.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) begin
                        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            q_data[wr_ptr_q] <= wr ? 32'h0 : mem[idx];
        end
    end

endmodule
